reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor of the datapath register file.
- Two combinational read ports and one synchronous write port, with:
  - an optional write-to-read bypass;
  - a per-register pending-write scoreboard, for a pipelined or multicycle CPU to detect RAW hazards;
  - a sequential clear engine that zeroes the file one register per cycle on request.
- Sits between the CPU control unit/bus and the ALU, in place of the fixed 8x16 file.

Parameters:
- WIDTH, 16, data width of each register and of BUS/SRxOUT.
- NREGS, 8, number of registers; power of two, at least 2.
- BYPASS, 1, 1 = read ports forward BUS when written this cycle; 0 = reads return stored value only.
- AW, $clog2(NREGS), register index width; derived, not overridden.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous, active-high.
- SR1  in  AW  read port 1 index.
- SR2  in  AW  read port 2 index.
- DR  in  AW  write index.
- BUS  in  WIDTH  write data.
- LD_REG  in  1  write enable.
- ISSUE  in  1  mark register ISSUE_DR as pending-write.
- ISSUE_DR  in  AW  index marked by ISSUE.
- CLR_REQ  in  1  start the sequential clear sweep.
- SR1OUT  out  WIDTH  read data, port 1.
- SR2OUT  out  WIDTH  read data, port 2.
- SR1_BUSY  out  1  SR1 has a pending write that is not satisfied this cycle.
- SR2_BUSY  out  1  same for SR2.
- CLR_BUSY  out  1  clear sweep in progress.

Behaviour:
- Reset (reset Reset, synchronous, active-high; clock Clk):
  - all registers go to 0, all busy bits to 0, FSM to IDLE, sweep counter to 0.
  - Reset overrides every other input in the same cycle, including mid-sweep.
  - After reset: SRxOUT = 0, SRx_BUSY = 0, CLR_BUSY = 0.
- Write:
  - In IDLE with LD_REG=1, Reg[DR] <= BUS at the next edge.
  - Every DR value is valid; there is no hardwired zero register.
- Read:
  - SRxOUT is combinational from Reg[SRx]; no latency.
  - With BYPASS=1, state IDLE, LD_REG=1 and DR==SRx: SRxOUT = BUS in the same cycle.
  - SR1==SR2 is legal; both ports return identical data.
- Scoreboard (NREGS bits):
  - ISSUE=1 sets busy[ISSUE_DR].
  - LD_REG=1 clears busy[DR].
  - ISSUE and LD_REG to the same index in the same cycle: set wins (new producer outstanding).
  - SRx_BUSY = busy[SRx], except SRx_BUSY = 0 when BYPASS=1, LD_REG=1, DR==SRx and state IDLE (hazard resolved by forwarding).
  - With BYPASS=0, SRx_BUSY stays 1 in the writeback cycle and drops the cycle after.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when CLR_REQ=1; counter <= 0.
  - In SWEEP, each cycle: Reg[counter] <= 0, busy[counter] <= 0, counter increments.
  - SWEEP -> IDLE on the edge that writes index NREGS-1.
  - Sweep length is exactly NREGS cycles. CLR_BUSY = 1 exactly when state is SWEEP.
  - During SWEEP: LD_REG, ISSUE and CLR_REQ are ignored (no write, no busy set, no restart). Bypass is disabled and reads return current contents, so registers already cleared read 0.
  - CLR_REQ together with LD_REG in IDLE: the write still occurs at that edge; the sweep then clears that register in its turn.
  - Counter is AW+1 bits or compared against NREGS-1; it must not wrap into a second pass.

Decomposition:
- Package reg_file_pkg: state enum {IDLE, SWEEP}; default WIDTH/NREGS constants.
- One natural sub-module, reg_scoreboard: busy bit vector with set/clear/priority and the per-port busy lookup. The storage array, bypass muxes and clear FSM stay in reg_file_sb.

Test Plan:
- Reset, then write R3=16'h1234, read SR1=3, SR2=3 next cycle -> both outputs 16'h1234, busy outputs 0.
- BYPASS=1: LD_REG=1, DR=5, BUS=16'hBEEF, SR1=5 in the same cycle -> SR1OUT=16'hBEEF that cycle; with BYPASS=0 -> old value, new value the next cycle.
- ISSUE with ISSUE_DR=2, then SR2=2 -> SR2_BUSY=1. Writeback DR=2 -> SR2_BUSY=0 in the same cycle (BYPASS=1) or the next cycle (BYPASS=0). ISSUE_DR=2 together with LD_REG DR=2 -> busy stays 1.
- Fill all 8 registers with nonzero values, pulse CLR_REQ:
  - CLR_BUSY=1 for exactly 8 cycles;
  - R0 reads 0 after the first sweep edge while R7 still holds its value;
  - all 0 when CLR_BUSY falls;
  - LD_REG/ISSUE/CLR_REQ pulsed mid-sweep have no effect.
- Assert Reset on sweep cycle 3 -> next cycle all registers 0, CLR_BUSY=0, busy bits 0; new writes accepted immediately.
- NREGS=16, WIDTH=32: write index 15 = 32'hDEADBEEF and index 0 = 32'h1 -> correct readback; sweep lasts 16 cycles.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the sweep-clearable register file.
// Holds the clear-engine state encoding and the legacy 8x16 geometry.
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;

  // IDLE: normal read/write; SWEEP: one register zeroed per cycle
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
// Busy lookup is combinational; a same-cycle forwarded writeback masks the hazard.
// A new issue beats a same-index writeback, because the new producer is still outstanding.
module reg_scoreboard #(
  parameter  int NREGS  = 8,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          wipe_en,
  input  logic [AW-1:0] wipe_idx,
  input  logic          fwd_en,
  input  logic [AW-1:0] fwd_idx,
  input  logic [AW-1:0] rd1_idx,
  input  logic [AW-1:0] rd2_idx,
  output logic          rd1_busy,
  output logic          rd2_busy
);

  localparam bit BYPASS_ON = (BYPASS != 0);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Next busy vector: wipe and writeback clear first, issue applied last so it wins
  always_comb begin
    busy_nxt = busy;
    if (wipe_en) busy_nxt[wipe_idx] = 1'b0;
    if (clr_en)  busy_nxt[clr_idx]  = 1'b0;
    if (set_en)  busy_nxt[set_idx]  = 1'b1;
  end

  // Busy state register, synchronously cleared by Reset
  always_ff @(posedge Clk) begin
    if (Reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // A read port is not stalled if the value it waits for is being forwarded right now
  always_comb begin
    rd1_busy = busy[rd1_idx];
    rd2_busy = busy[rd2_idx];
    if (BYPASS_ON && fwd_en && (fwd_idx == rd1_idx)) rd1_busy = 1'b0;
    if (BYPASS_ON && fwd_en && (fwd_idx == rd2_idx)) rd2_busy = 1'b0;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one synchronous write port,
// optional write-to-read forwarding, a RAW-hazard scoreboard and a sequential
// clear engine that zeroes one register per cycle while CLR_BUSY is high.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] BUS,
  input  logic             LD_REG,
  input  logic             ISSUE,
  input  logic [AW-1:0]    ISSUE_DR,
  input  logic             CLR_REQ,
  output logic [WIDTH-1:0] SR1OUT,
  output logic [WIDTH-1:0] SR2OUT,
  output logic             SR1_BUSY,
  output logic             SR2_BUSY,
  output logic             CLR_BUSY
);

  localparam bit            BYPASS_ON = (BYPASS != 0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

  logic [WIDTH-1:0] regs [NREGS];
  state_t           state;
  logic [AW-1:0]    sweep_idx;
  logic             clr_busy_q;
  logic             sweeping;
  logic             wr_en;
  logic             issue_en;

  // During a sweep every external write/issue/clear request is ignored
  assign sweeping = (state == SWEEP);
  assign wr_en    = LD_REG & ~sweeping;
  assign issue_en = ISSUE & ~sweeping;
  assign CLR_BUSY = clr_busy_q;

  // Clear engine: IDLE <-> SWEEP, walks sweep_idx 0..NREGS-1 exactly once per request
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      sweep_idx  <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CLR_REQ) begin
            state      <= SWEEP;
            sweep_idx  <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        SWEEP: begin
          if (sweep_idx == LAST_IDX) begin
            state      <= IDLE;
            sweep_idx  <= '0;
            clr_busy_q <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + AW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          sweep_idx  <= '0;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage: reset clears all, the sweep zeroes its current index, otherwise normal write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (sweeping) begin
      regs[sweep_idx] <= '0;
    end else if (wr_en) begin
      regs[DR] <= BUS;
    end
  end

  // Read muxes: forward BUS when the same index is written this cycle (never mid-sweep)
  always_comb begin
    SR1OUT = regs[SR1];
    SR2OUT = regs[SR2];
    if (BYPASS_ON && wr_en && (DR == SR1)) SR1OUT = BUS;
    if (BYPASS_ON && wr_en && (DR == SR2)) SR2OUT = BUS;
  end

  reg_scoreboard #(
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .Clk      (Clk),
    .Reset    (Reset),
    .set_en   (issue_en),
    .set_idx  (ISSUE_DR),
    .clr_en   (wr_en),
    .clr_idx  (DR),
    .wipe_en  (sweeping),
    .wipe_idx (sweep_idx),
    .fwd_en   (wr_en),
    .fwd_idx  (DR),
    .rd1_idx  (SR1),
    .rd2_idx  (SR2),
    .rd1_busy (SR1_BUSY),
    .rd2_busy (SR2_BUSY)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: bypass and non-bypass 8x16 instances share one stimulus
// stream checked every cycle against an array model; a 16x32 instance gets directed checks.
module tb_reg_file_sb;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  SR1, SR2, DR, ISSUE_DR;
  logic [15:0] BUS;
  logic        LD_REG, ISSUE, CLR_REQ;

  logic [15:0] a_o1, a_o2, b_o1, b_o2;
  logic        a_b1, a_b2, a_cb, b_b1, b_b2, b_cb;

  logic [3:0]  c_sr1, c_sr2, c_dr, c_idr;
  logic [31:0] c_bus, c_o1, c_o2;
  logic        c_ld, c_issue, c_clr, c_b1, c_b2, c_cb;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [8];
  bit          m_busy [8];
  bit          m_sw;
  int          m_idx;

  always #5 Clk = ~Clk;

  reg_file_sb #(.WIDTH(16), .NREGS(8), .BYPASS(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .SR1(SR1), .SR2(SR2), .DR(DR), .BUS(BUS),
    .LD_REG(LD_REG), .ISSUE(ISSUE), .ISSUE_DR(ISSUE_DR), .CLR_REQ(CLR_REQ),
    .SR1OUT(a_o1), .SR2OUT(a_o2), .SR1_BUSY(a_b1), .SR2_BUSY(a_b2), .CLR_BUSY(a_cb));

  reg_file_sb #(.WIDTH(16), .NREGS(8), .BYPASS(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .SR1(SR1), .SR2(SR2), .DR(DR), .BUS(BUS),
    .LD_REG(LD_REG), .ISSUE(ISSUE), .ISSUE_DR(ISSUE_DR), .CLR_REQ(CLR_REQ),
    .SR1OUT(b_o1), .SR2OUT(b_o2), .SR1_BUSY(b_b1), .SR2_BUSY(b_b2), .CLR_BUSY(b_cb));

  reg_file_sb #(.WIDTH(32), .NREGS(16), .BYPASS(1)) dut_c (
    .Clk(Clk), .Reset(Reset), .SR1(c_sr1), .SR2(c_sr2), .DR(c_dr), .BUS(c_bus),
    .LD_REG(c_ld), .ISSUE(c_issue), .ISSUE_DR(c_idr), .CLR_REQ(c_clr),
    .SR1OUT(c_o1), .SR2OUT(c_o2), .SR1_BUSY(c_b1), .SR2_BUSY(c_b2), .CLR_BUSY(c_cb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected read data: a same-cycle write is visible only with forwarding and outside a sweep
  function automatic logic [15:0] exp_out(input logic [2:0] sr, input bit byp);
    if (byp && !m_sw && LD_REG && DR == sr) return BUS;
    return m_mem[sr];
  endfunction

  function automatic logic exp_busy(input logic [2:0] sr, input bit byp);
    if (byp && !m_sw && LD_REG && DR == sr) return 1'b0;
    return m_busy[sr];
  endfunction

  task automatic check_ab();
    chk("a_sr1out",  a_o1, exp_out(SR1, 1'b1));
    chk("a_sr2out",  a_o2, exp_out(SR2, 1'b1));
    chk("a_sr1busy", a_b1, exp_busy(SR1, 1'b1));
    chk("a_sr2busy", a_b2, exp_busy(SR2, 1'b1));
    chk("a_clrbusy", a_cb, m_sw);
    chk("b_sr1out",  b_o1, exp_out(SR1, 1'b0));
    chk("b_sr2out",  b_o2, exp_out(SR2, 1'b0));
    chk("b_sr1busy", b_b1, exp_busy(SR1, 1'b0));
    chk("b_sr2busy", b_b2, exp_busy(SR2, 1'b0));
    chk("b_clrbusy", b_cb, m_sw);
  endtask

  // Model of one clock edge, written from the behavioural rules
  task automatic model_update();
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
      m_sw = 1'b0; m_idx = 0;
    end else if (m_sw) begin
      m_mem[m_idx] = '0; m_busy[m_idx] = 1'b0;
      m_idx++;
      if (m_idx == 8) begin m_sw = 1'b0; m_idx = 0; end
    end else begin
      if (LD_REG) begin m_mem[DR] = BUS; m_busy[DR] = 1'b0; end
      if (ISSUE) m_busy[ISSUE_DR] = 1'b1;
      if (CLR_REQ) begin m_sw = 1'b1; m_idx = 0; end
    end
  endtask

  // Inputs are already set (we are just past a negedge): check, clock, update model
  task automatic step();
    #1;
    check_ab();
    @(posedge Clk);
    model_update();
    @(negedge Clk);
  endtask

  task automatic idle_ab();
    LD_REG = 0; ISSUE = 0; CLR_REQ = 0; Reset = 0;
  endtask

  task automatic step_c();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    Reset = 1; SR1 = 0; SR2 = 0; DR = 0; ISSUE_DR = 0; BUS = 0;
    LD_REG = 0; ISSUE = 0; CLR_REQ = 0;
    c_sr1 = 0; c_sr2 = 0; c_dr = 0; c_idr = 0; c_bus = 0; c_ld = 0; c_issue = 0; c_clr = 0;
    for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    m_sw = 0; m_idx = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 0;

    // Reset state
    #1;
    chk("rst_sr1out", a_o1, 16'h0);
    chk("rst_sr1busy", a_b1, 1'b0);
    chk("rst_clrbusy", a_cb, 1'b0);
    chk("rst_c_clrbusy", c_cb, 1'b0);
    step();

    // Basic write then dual read of the same register
    LD_REG = 1; DR = 3; BUS = 16'h1234; step();
    LD_REG = 0; SR1 = 3; SR2 = 3; #1;
    chk("r3_sr1", a_o1, 16'h1234);
    chk("r3_sr2", a_o2, 16'h1234);
    chk("r3_b_sr1", b_o1, 16'h1234);
    chk("r3_busy", a_b1, 1'b0);
    step();

    // Same-cycle forwarding vs stored-value read
    LD_REG = 1; DR = 5; BUS = 16'hBEEF; SR1 = 5; #1;
    chk("byp_a_same", a_o1, 16'hBEEF);
    chk("byp_b_old", b_o1, 16'h0);
    step();
    LD_REG = 0; #1;
    chk("byp_b_next", b_o1, 16'hBEEF);
    step();

    // Scoreboard: issue, writeback, and issue+writeback collision
    ISSUE = 1; ISSUE_DR = 2; step();
    ISSUE = 0; SR2 = 2; #1;
    chk("sb_a_busy", a_b2, 1'b1);
    chk("sb_b_busy", b_b2, 1'b1);
    step();
    LD_REG = 1; DR = 2; BUS = 16'h7777; #1;
    chk("sb_a_wb_same", a_b2, 1'b0);
    chk("sb_b_wb_same", b_b2, 1'b1);
    step();
    LD_REG = 0; #1;
    chk("sb_b_wb_next", b_b2, 1'b0);
    step();
    ISSUE = 1; ISSUE_DR = 2; LD_REG = 1; DR = 2; BUS = 16'h5555; step();
    idle_ab(); #1;
    chk("sb_a_setwins", a_b2, 1'b1);
    chk("sb_b_setwins", b_b2, 1'b1);
    step();

    // Fill all registers, then sweep with ignored mid-sweep requests
    for (int i = 0; i < 8; i++) begin
      LD_REG = 1; DR = 3'(i); BUS = 16'(16'h1111 * (i + 1)); step();
    end
    idle_ab(); SR1 = 0; SR2 = 7;
    CLR_REQ = 1; step();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      idle_ab();
      if (n == 4) begin
        LD_REG = 1; DR = 1; BUS = 16'hFFFF; ISSUE = 1; ISSUE_DR = 6; CLR_REQ = 1;
      end
      #1;
      if (a_cb !== 1'b1) break;
      n++;
      step();
      if (n == 1) begin
        #1;
        chk("sweep_r0_cleared", a_o1, 16'h0);
        chk("sweep_r7_held", a_o2, 16'h8888);
      end
    end
    chk("sweep_len", n, 8);
    idle_ab();
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(i); #1;
      chk("sweep_zero", a_o1, 16'h0);
      chk("sweep_busy0", a_b1, 1'b0);
      step();
    end

    // Reset asserted on sweep cycle 3
    for (int i = 0; i < 8; i++) begin
      LD_REG = 1; DR = 3'(i); BUS = 16'(16'hA000 + i); step();
    end
    idle_ab(); ISSUE = 1; ISSUE_DR = 7; step();
    idle_ab(); CLR_REQ = 1; step();
    idle_ab(); step(); step();
    Reset = 1; step();
    idle_ab(); SR1 = 7; #1;
    chk("rst_mid_clrbusy", a_cb, 1'b0);
    chk("rst_mid_busy7", a_b1, 1'b0);
    chk("rst_mid_r7", a_o1, 16'h0);
    step();
    LD_REG = 1; DR = 4; BUS = 16'h4242; step();
    LD_REG = 0; SR1 = 4; #1;
    chk("rst_mid_newwrite", a_o1, 16'h4242);
    step();

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      Reset    = ($urandom_range(0, 63) == 0);
      LD_REG   = 1'($urandom);
      ISSUE    = 1'($urandom);
      CLR_REQ  = ($urandom_range(0, 31) == 0);
      SR1      = 3'($urandom);
      SR2      = 3'($urandom);
      DR       = 3'($urandom);
      ISSUE_DR = 3'($urandom);
      BUS      = 16'($urandom);
      step();
    end
    idle_ab();
    repeat (10) step();

    // 16x32 instance: extreme indices, forwarding, 16-cycle sweep
    c_ld = 1; c_dr = 15; c_bus = 32'hDEADBEEF; step_c();
    c_dr = 0; c_bus = 32'h1; step_c();
    c_ld = 0; c_sr1 = 15; c_sr2 = 0; #1;
    chk("c_r15", c_o1, 32'hDEADBEEF);
    chk("c_r0", c_o2, 32'h1);
    c_ld = 1; c_dr = 9; c_bus = 32'hCAFEF00D; c_sr2 = 9; #1;
    chk("c_byp", c_o2, 32'hCAFEF00D);
    step_c();
    c_ld = 0; c_clr = 1; step_c();
    c_clr = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (c_cb !== 1'b1) break;
      n++;
      step_c();
    end
    chk("c_sweep_len", n, 16);
    #1;
    chk("c_r15_cleared", c_o1, 32'h0);
    chk("c_r9_cleared", c_o2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
